muldiv_seq_ctrl: RTL
====================

Name: muldiv_seq_ctrl

Overview:
Multi-cycle sequencer for the RV32M operations that the ALU control unit decodes: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Sits beside the single-cycle ALU in the execute stage.
- Accepts an M-extension ALU_sel plus two operands.
- Runs an iterative shift-add multiply or restoring divide, and stalls the pipeline until the result is ready.
- Produces a one-cycle done pulse with the held result.

Parameters:
XLEN, 32, operand/result width; the iteration counter is clog2(XLEN)+1 bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  execute stage presents an operation this cycle.
- flush  input  1  synchronous abort of any in-flight operation.
- ALU_sel  input  5  operation code, using the same ALU_* encodings as the ALU control unit.
- op_a  input  XLEN  rs1 operand.
- op_b  input  XLEN  rs2 operand.
- result  output  XLEN  final value; held until the next accepted start.
- busy  output  1  operation in flight (PREP, CALC or FIX).
- stall  output  1  combinational: busy | (start & is_m & state is IDLE or DONE).
- done  output  1  one-cycle pulse; result is valid in this cycle.

Behaviour:
- Single clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- is_m is true when ALU_sel is one of ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU.
- Start with a non-M ALU_sel is ignored: no state change, stall stays low.
- Reset: state=IDLE; result=0, busy=0, done=0. Counter, accumulators and sign flags are cleared.
- rst takes priority over flush, and flush takes priority over start.
- States:
  - IDLE: start&is_m -> PREP. Latch ALU_sel, op_a, op_b.
  - PREP: compute operand magnitudes and sign flags per op (MULHSU: op_a signed, op_b unsigned). Divide special cases go straight to DONE with the result loaded. Otherwise clear counter -> CALC.
  - CALC: one radix-2 iteration per cycle; after XLEN iterations (counter==XLEN-1) -> FIX.
  - FIX: apply sign correction; select the low word (MUL) or high word (MULH*). Select quotient or remainder for divides -> DONE.
  - DONE: done=1. start&is_m -> PREP (back-to-back accepted); otherwise -> IDLE.
- Latency, with the start cycle as cycle 0:
  - Normal path: done in cycle XLEN+3 (35 for XLEN=32).
  - Special cases: done in cycle 2.
  - stall is high in cycles 0 through XLEN+2 and low in the DONE cycle.
- Start while busy is ignored (the pipeline is stalled, so it cannot legally occur).
- Divide special cases:
  - Divisor 0: DIV/DIVU quotient = all ones; REM/REMU = op_a.
  - Signed overflow (op_a=0x80000000, op_b=all ones): DIV = 0x80000000; REM = 0.
- Signed sign rules: quotient negative iff the signs differ; remainder takes the sign of the dividend.
- Unsigned ops never negate.
- flush or rst mid-operation: back to IDLE next edge, no done pulse, result keeps its previous value (0 after rst).

Optional Feature:
MULDIV_FAST_MUL_EN.
- Defined: multiply ops compute the full 2*XLEN product with the * operator in PREP and go to DONE, so done arrives in cycle 2. Divides are unchanged.
- Undefined: multiplies use the iterative CALC path (XLEN+3 latency), and no hardware multiplier is inferred.

Decomposition:
- defines.v gets the state encodings (MDS_IDLE, MDS_PREP, MDS_CALC, MDS_FIX, MDS_DONE, 3 bits) and reuses the existing ALU_* codes.
- Sub-module muldiv_iter_step: combinational single iteration, covering the shift-add step and the restoring subtract/compare-and-shift step, selected by a mul/div flag. The FSM, counter and registers stay in muldiv_seq_ctrl.

Test Plan:
- ALU_MUL, op_a=7, op_b=0xFFFFFFFD: stall high cycles 0-34; done in cycle 35; result=0xFFFFFFEB. With MULDIV_FAST_MUL_EN defined: done in cycle 2.
- ALU_MULHU, 0xFFFFFFFF*0xFFFFFFFF -> result 0xFFFFFFFE. ALU_MULHSU, op_a=0xFFFFFFFF, op_b=2 -> result 0xFFFFFFFF.
- ALU_DIV, -7/2 -> 0xFFFFFFFD; ALU_REM, -7/2 -> 0xFFFFFFFF. Each has done in cycle 35.
- Special cases, each with done in cycle 2:
  - ALU_DIVU 13/0 -> 0xFFFFFFFF.
  - ALU_REMU 13/0 -> 13.
  - ALU_DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - ALU_REM of the same operands -> 0.
- Abort: start ALU_DIV, assert flush in cycle 10 -> busy=0 in cycle 11, no done, result unchanged. Repeat with rst instead of flush -> result=0.
- Gating and back-to-back: start with ALU_ADD -> stall=0, no state change. Two MULs back-to-back (start held in the DONE cycle) -> second done exactly 35 cycles after the first.

Source files
------------

// File: rtl/muldiv_seq_ctrl_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: ALU operation
// codes, FSM state encodings and the M-extension decode helper.
package muldiv_seq_ctrl_pkg;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_MUL    = 5'd10;
    localparam logic [4:0] ALU_MULH   = 5'd11;
    localparam logic [4:0] ALU_MULHSU = 5'd12;
    localparam logic [4:0] ALU_MULHU  = 5'd13;
    localparam logic [4:0] ALU_DIV    = 5'd14;
    localparam logic [4:0] ALU_DIVU   = 5'd15;
    localparam logic [4:0] ALU_REM    = 5'd16;
    localparam logic [4:0] ALU_REMU   = 5'd17;

    typedef enum logic [2:0] {
        MDS_IDLE = 3'd0,
        MDS_PREP = 3'd1,
        MDS_CALC = 3'd2,
        MDS_FIX  = 3'd3,
        MDS_DONE = 3'd4
    } md_state_t;

    function automatic logic is_m_op(input logic [4:0] sel);
        return sel inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                           ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

endpackage

// File: rtl/muldiv_seq_ctrl_iter_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step,
// operating on the shared {hi, lo} accumulator pair.
module muldiv_iter_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        shifted = {hi, lo[XLEN-1]};
        // remainder stays below the divisor, so XLEN+1 bits hold the signed difference
        diff    = shifted - {1'b0, opnd};
        if (is_div) begin
            if (!diff[XLEN]) begin
                hi_next = diff[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_next = shifted[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_next = sum[XLEN:1];
            lo_next = {sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// Multi-cycle RV32M multiply/divide sequencer with pipeline stall and done pulse.
// Define MULDIV_FAST_MUL_EN to compute multiplies in one shot with the * operator.
//
// state     | meaning
// MDS_IDLE  | waiting for an accepted M-extension start
// MDS_PREP  | magnitudes/sign flags, divide special cases
// MDS_CALC  | one radix-2 iteration per cycle, XLEN iterations
// MDS_FIX   | sign correction and word/quotient/remainder select
// MDS_DONE  | done pulse, result valid
module muldiv_seq_ctrl
    import muldiv_seq_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [4:0]      ALU_sel,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic            stall,
    output logic            done
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    md_state_t state, state_nxt;
    logic [4:0]       sel_q;
    logic [XLEN-1:0]  a_q, b_q, hi_q, lo_q, opnd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_quo, neg_rem;

    logic             is_m, accept, is_div_op, signed_a, signed_b, sign_a, sign_b;
    logic             div_zero, div_ovf, special, skip;
    logic [XLEN-1:0]  mag_a, mag_b, special_res, skip_res, quo, rem, fix_res;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]  step_hi, step_lo;

    assign is_m   = is_m_op(ALU_sel);
    assign accept = start && is_m && !flush && (state == MDS_IDLE || state == MDS_DONE);

    always_comb begin
        is_div_op   = sel_q inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
        signed_a    = sel_q inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
        signed_b    = sel_q inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
        sign_a      = signed_a & a_q[XLEN-1];
        sign_b      = signed_b & b_q[XLEN-1];
        mag_a       = sign_a ? -a_q : a_q;
        mag_b       = sign_b ? -b_q : b_q;
        div_zero    = (b_q == '0);
        div_ovf     = (sel_q inside {ALU_DIV, ALU_REM}) &&
                      (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
        special     = is_div_op && (div_zero || div_ovf);
        if (div_zero)
            special_res = (sel_q inside {ALU_DIV, ALU_DIVU}) ? '1 : a_q;
        else
            special_res = (sel_q == ALU_DIV) ? a_q : '0;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] prod_fast;
    assign prod_fast = $signed({{XLEN{sign_a}}, a_q}) * $signed({{XLEN{sign_b}}, b_q});
    assign skip      = special || !is_div_op;
    assign skip_res  = special ? special_res :
                       (sel_q == ALU_MUL) ? prod_fast[XLEN-1:0] : prod_fast[2*XLEN-1:XLEN];
`else
    assign skip      = special;
    assign skip_res  = special_res;
`endif

    always_comb begin
        prod   = {hi_q, lo_q};
        prod_s = neg_quo ? -prod : prod;
        quo    = neg_quo ? -lo_q : lo_q;
        rem    = neg_rem ? -hi_q : hi_q;
        unique case (sel_q)
            ALU_MUL:                        fix_res = prod_s[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:              fix_res = quo;
            default:                        fix_res = rem;
        endcase
    end

    muldiv_iter_step #(.XLEN(XLEN)) u_step (
        .is_div  (is_div_op),
        .hi      (hi_q),
        .lo      (lo_q),
        .opnd    (opnd_q),
        .hi_next (step_hi),
        .lo_next (step_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= MDS_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            MDS_IDLE: if (start && is_m) state_nxt = MDS_PREP;
            MDS_PREP: state_nxt = skip ? MDS_DONE : MDS_CALC;
            MDS_CALC: if (cnt_q == CNT_W'(XLEN-1)) state_nxt = MDS_FIX;
            MDS_FIX:  state_nxt = MDS_DONE;
            MDS_DONE: state_nxt = (start && is_m) ? MDS_PREP : MDS_IDLE;
            default:  state_nxt = MDS_IDLE;
        endcase
        if (flush) state_nxt = MDS_IDLE;
    end

    always_comb begin
        busy  = (state == MDS_PREP) || (state == MDS_CALC) || (state == MDS_FIX);
        done  = (state == MDS_DONE);
        stall = busy || (start && is_m && (state == MDS_IDLE || state == MDS_DONE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
            result  <= '0;
        end else begin
            if (accept) begin
                sel_q <= ALU_sel;
                a_q   <= op_a;
                b_q   <= op_b;
            end
            unique case (state)
                MDS_PREP: begin
                    hi_q    <= '0;
                    lo_q    <= mag_a;
                    opnd_q  <= mag_b;
                    cnt_q   <= '0;
                    neg_quo <= sign_a ^ sign_b;
                    neg_rem <= sign_a;
                    if (skip && !flush) result <= skip_res;
                end
                MDS_CALC: begin
                    hi_q  <= step_hi;
                    lo_q  <= step_lo;
                    cnt_q <= cnt_q + 1'b1;
                end
                MDS_FIX: if (!flush) result <= fix_res;
                default: ;
            endcase
        end
    end

endmodule
